// File: rtl/hazard_scoreboard_if.sv
// Decode-side bundle between the pipeline decode stage and the hazard scoreboard.
// The master drives the decoded instruction; the slave returns stall/flush/forwarding.
interface hazard_scoreboard_if #(
    parameter int REG_AW = 4,
    parameter int STAGES = 3,
    parameter int CNT_W  = 16,
    parameter int SW     = $clog2(STAGES + 1)
);
    logic              dec_valid;
    logic [REG_AW-1:0] dec_rs1;
    logic              dec_rs1_used;
    logic [REG_AW-1:0] dec_rs2;
    logic              dec_rs2_used;
    logic [REG_AW-1:0] dec_rd;
    logic              dec_rd_we;
    logic              dec_is_load;
    logic              branch_taken;
    logic              hold;
    logic              stall;
    logic              flush;
    logic [SW-1:0]     fwd_sel1;
    logic [SW-1:0]     fwd_sel2;
    logic [SW-1:0]     inflight;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output dec_valid, dec_rs1, dec_rs1_used, dec_rs2, dec_rs2_used,
               dec_rd, dec_rd_we, dec_is_load, branch_taken, hold,
        input  stall, flush, fwd_sel1, fwd_sel2, inflight, stall_cnt
    );

    modport slave (
        input  dec_valid, dec_rs1, dec_rs1_used, dec_rs2, dec_rs2_used,
               dec_rd, dec_rd_we, dec_is_load, branch_taken, hold,
        output stall, flush, fwd_sel1, fwd_sel2, inflight, stall_cnt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding controller: shift scoreboard of in-flight destinations (slot 1 =
// execute), youngest-match forwarding selects, load-use stall, branch flush, stall counter.
module hazard_scoreboard #(
    parameter int REG_AW   = 4,
    parameter int STAGES   = 3,
    parameter int ZERO_REG = 0,
    parameter int CNT_W    = 16,
    localparam int SW      = $clog2(STAGES + 1)
) (
    input logic               clk,
    input logic               reset,
    hazard_scoreboard_if.slave bus
);
    logic [STAGES:1]              valid_reg;
    logic [STAGES:1]              we_reg;
    logic [STAGES:1]              ld_reg;
    logic [STAGES:1][REG_AW-1:0]  rd_reg;
    logic [CNT_W-1:0]             stall_cnt_reg;

    logic [STAGES:1] match1;
    logic [STAGES:1] match2;
    logic            zero1;
    logic            zero2;
    logic [SW-1:0]   sel1;
    logic [SW-1:0]   sel2;
    logic [SW-1:0]   inflight_cnt;
    logic            load_use;
    logic            stall;

    // Register 0 never matches when it is hardwired to zero.
    assign zero1 = (ZERO_REG != 0) && (bus.dec_rs1 == '0);
    assign zero2 = (ZERO_REG != 0) && (bus.dec_rs2 == '0);

    genvar gi;
    generate
        for (gi = 1; gi <= STAGES; gi++) begin : g_match
            assign match1[gi] = bus.dec_valid & bus.dec_rs1_used & valid_reg[gi] & we_reg[gi]
                              & (rd_reg[gi] == bus.dec_rs1) & ~zero1;
            assign match2[gi] = bus.dec_valid & bus.dec_rs2_used & valid_reg[gi] & we_reg[gi]
                              & (rd_reg[gi] == bus.dec_rs2) & ~zero2;
        end
    endgenerate

    // Scan oldest to youngest so the youngest (lowest slot) match is the last to land.
    always_comb begin
        sel1 = '0;
        sel2 = '0;
        for (int k = STAGES; k >= 1; k--) begin
            if (match1[k]) sel1 = SW'(k);
            if (match2[k]) sel2 = SW'(k);
        end
    end

    always_comb begin
        inflight_cnt = '0;
        for (int k = 1; k <= STAGES; k++) begin
            inflight_cnt = inflight_cnt + SW'(valid_reg[k] & we_reg[k]);
        end
    end

    // A slot-1 match is always the winner, so only slot 1 can create a load-use hazard.
    assign load_use = ld_reg[1] & (match1[1] | match2[1]);
    assign stall    = bus.hold | load_use;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_reg <= '0;
            we_reg    <= '0;
            ld_reg    <= '0;
            rd_reg    <= '0;
        end else if (!bus.hold) begin
            for (int k = STAGES; k >= 2; k--) begin
                valid_reg[k] <= valid_reg[k-1];
                we_reg[k]    <= we_reg[k-1];
                ld_reg[k]    <= ld_reg[k-1];
                rd_reg[k]    <= rd_reg[k-1];
            end
            if (load_use) begin
                valid_reg[1] <= 1'b0;
                we_reg[1]    <= 1'b0;
                ld_reg[1]    <= 1'b0;
                rd_reg[1]    <= '0;
            end else begin
                valid_reg[1] <= bus.dec_valid;
                we_reg[1]    <= bus.dec_rd_we;
                ld_reg[1]    <= bus.dec_is_load;
                rd_reg[1]    <= bus.dec_rd;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_reg <= '0;
        end else if (stall && (stall_cnt_reg != {CNT_W{1'b1}})) begin
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
        end
    end

    assign bus.stall     = stall;
    assign bus.flush     = bus.branch_taken & bus.dec_valid & ~stall;
    assign bus.fwd_sel1  = sel1;
    assign bus.fwd_sel2  = sel2;
    assign bus.inflight  = inflight_cnt;
    assign bus.stall_cnt = stall_cnt_reg;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: default instance (ZERO_REG=0, CNT_W=16) plus a ZERO_REG=1, CNT_W=4
// instance for the hardwired-zero, saturation and mid-cycle reset cases.
module tb_hazard_scoreboard;
    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    hazard_scoreboard_if #(.REG_AW(4), .STAGES(3), .CNT_W(16)) if0 ();
    hazard_scoreboard_if #(.REG_AW(4), .STAGES(3), .CNT_W(4))  if1 ();

    hazard_scoreboard #(.REG_AW(4), .STAGES(3), .ZERO_REG(0), .CNT_W(16)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (if0)
    );

    hazard_scoreboard #(.REG_AW(4), .STAGES(3), .ZERO_REG(1), .CNT_W(4)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input int v, input int rs1, input int u1, input int rs2, input int u2,
                          input int rd, input int we, input int ld, input int br, input int hd);
        if0.dec_valid    = (v != 0);
        if0.dec_rs1      = 4'(rs1);
        if0.dec_rs1_used = (u1 != 0);
        if0.dec_rs2      = 4'(rs2);
        if0.dec_rs2_used = (u2 != 0);
        if0.dec_rd       = 4'(rd);
        if0.dec_rd_we    = (we != 0);
        if0.dec_is_load  = (ld != 0);
        if0.branch_taken = (br != 0);
        if0.hold         = (hd != 0);
        #1;
    endtask

    task automatic drive1(input int v, input int rs1, input int u1, input int rs2, input int u2,
                          input int rd, input int we, input int ld, input int hd);
        if1.dec_valid    = (v != 0);
        if1.dec_rs1      = 4'(rs1);
        if1.dec_rs1_used = (u1 != 0);
        if1.dec_rs2      = 4'(rs2);
        if1.dec_rs2_used = (u2 != 0);
        if1.dec_rd       = 4'(rd);
        if1.dec_rd_we    = (we != 0);
        if1.dec_is_load  = (ld != 0);
        if1.branch_taken = 1'b0;
        if1.hold         = (hd != 0);
        #1;
    endtask

    task automatic expect0(input string tag, input int st, input int fl, input int s1,
                           input int s2, input int inf, input int cnt);
        check({tag, ".stall"},     32'(if0.stall),     st);
        check({tag, ".flush"},     32'(if0.flush),     fl);
        check({tag, ".fwd_sel1"},  32'(if0.fwd_sel1),  s1);
        check({tag, ".fwd_sel2"},  32'(if0.fwd_sel2),  s2);
        check({tag, ".inflight"},  32'(if0.inflight),  inf);
        check({tag, ".stall_cnt"}, 32'(if0.stall_cnt), cnt);
    endtask

    task automatic expect1(input string tag, input int st, input int s1, input int s2,
                           input int inf, input int cnt);
        check({tag, ".stall"},     32'(if1.stall),     st);
        check({tag, ".fwd_sel1"},  32'(if1.fwd_sel1),  s1);
        check({tag, ".fwd_sel2"},  32'(if1.fwd_sel2),  s2);
        check({tag, ".inflight"},  32'(if1.inflight),  inf);
        check({tag, ".stall_cnt"}, 32'(if1.stall_cnt), cnt);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        drive0(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive1(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        expect0("reset", 0, 0, 0, 0, 0, 0);
        expect1("reset1", 0, 0, 0, 0, 0);

        // ALU write r5, then read r5 as rs1
        drive0(1, 0, 0, 0, 0, 5, 1, 0, 0, 0); expect0("alu_r5", 0, 0, 0, 0, 0, 0); tick();
        drive0(1, 5, 1, 2, 1, 6, 1, 0, 0, 0); expect0("fwd_r5", 0, 0, 1, 0, 1, 0); tick();

        // load r3 then use: one stall cycle, then forward from slot 2
        drive0(1, 0, 0, 0, 0, 3, 1, 1, 0, 0); expect0("ld_r3", 0, 0, 0, 0, 2, 0); tick();
        drive0(1, 3, 1, 0, 0, 4, 1, 0, 0, 0); expect0("ld_use", 1, 0, 1, 0, 3, 0); tick();
        expect0("ld_fwd", 0, 0, 2, 0, 2, 1); tick();

        // r7 at slots 1 and 3: youngest wins
        drive0(1, 0, 0, 0, 0, 7, 1, 0, 0, 0); tick();
        drive0(1, 0, 0, 0, 0, 8, 1, 0, 0, 0); tick();
        drive0(1, 0, 0, 0, 0, 7, 1, 0, 0, 0); tick();
        drive0(1, 7, 1, 7, 1, 0, 0, 0, 0, 0); expect0("young", 0, 0, 1, 1, 3, 1); tick();
        drive0(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        drive0(1, 7, 1, 0, 0, 0, 0, 0, 0, 0); expect0("old3", 0, 0, 3, 0, 1, 1); tick();

        // load matched only by source 2 still stalls
        drive0(1, 0, 0, 0, 0, 9, 1, 1, 0, 0); expect0("ld_r9", 0, 0, 0, 0, 0, 1); tick();
        drive0(1, 1, 1, 9, 1, 0, 0, 0, 0, 0); expect0("ld_src2", 1, 0, 0, 1, 1, 1); tick();
        expect0("ld_src2_fwd", 0, 0, 0, 2, 1, 2); tick();

        // taken branch under a load-use stall: flush deferred one cycle
        drive0(1, 0, 0, 0, 0, 10, 1, 1, 0, 0); expect0("ld_r10", 0, 0, 0, 0, 1, 2); tick();
        drive0(1, 10, 1, 0, 0, 11, 1, 0, 1, 0); expect0("br_stall", 1, 0, 1, 0, 1, 2); tick();
        expect0("br_flush", 0, 1, 2, 0, 1, 3); tick();
        drive0(1, 11, 1, 10, 1, 0, 0, 0, 0, 0); expect0("br_slot1", 0, 0, 1, 3, 2, 3); tick();

        // hold with three writers in flight freezes the scoreboard
        drive0(1, 0, 0, 0, 0, 1, 1, 0, 0, 0); tick();
        drive0(1, 0, 0, 0, 0, 2, 1, 0, 0, 0); tick();
        drive0(1, 0, 0, 0, 0, 3, 1, 0, 0, 0); tick();
        drive0(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            expect0($sformatf("hold%0d", i), 1, 0, 0, 0, 3, 3 + i);
            tick();
        end
        drive0(1, 1, 1, 3, 1, 0, 0, 0, 0, 0); expect0("post_hold", 0, 0, 3, 1, 3, 7); tick();
        drive0(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // hardwired r0: a load to r0 never forwards or stalls
        drive1(1, 0, 0, 0, 0, 0, 1, 1, 0); expect1("z_ld", 0, 0, 0, 0, 0); tick();
        drive1(1, 0, 1, 0, 1, 5, 1, 0, 0); expect1("z_read", 0, 0, 0, 1, 0); tick();

        // 4-bit stall counter saturates at 15
        drive1(0, 0, 0, 0, 0, 0, 0, 0, 1);
        repeat (20) tick();
        expect1("sat", 1, 0, 0, 2, 15);

        // asynchronous reset in the middle of a load-use stall
        drive1(1, 0, 0, 0, 0, 4, 1, 1, 0); tick();
        drive1(1, 4, 1, 5, 1, 0, 0, 0, 0); expect1("z_lduse", 1, 1, 2, 3, 15);
        #2 reset = 1'b1;
        #1;
        expect1("rst_mid", 0, 0, 0, 0, 0);
        check("rst_mid0.inflight", 32'(if0.inflight), 0);
        check("rst_mid0.stall_cnt", 32'(if0.stall_cnt), 0);
        tick();
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised hazard and forwarding controller for the in-order pipeline (fetch, decode, execute, memory, writeback).
- Tracks in-flight destination registers in a shift scoreboard of depth STAGES, one slot per post-decode stage.
- Generates operand forwarding selects, load-use stall, branch flush and a saturating stall counter.
- Sits beside the decode stage; its outputs drive the fetch/decode pipeline-register enables and the operand muxes feeding the execute register.

Parameters:
REG_AW, 4, register address width (2**REG_AW architectural registers)
STAGES, 3, post-decode stages tracked (slot 1 = execute, 2 = memory, 3 = writeback); legal range 2..8
ZERO_REG, 0, when 1, register 0 is hardwired zero: never matched, never forwarded
CNT_W, 16, stall counter width
SW, $clog2(STAGES+1), width of forwarding selects

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
dec_valid  in  1  decode holds a valid instruction
dec_rs1  in  REG_AW  source 1 address
dec_rs1_used  in  1  source 1 is read
dec_rs2  in  REG_AW  source 2 address
dec_rs2_used  in  1  source 2 is read
dec_rd  in  REG_AW  destination address
dec_rd_we  in  1  instruction writes rd
dec_is_load  in  1  instruction is a load
branch_taken  in  1  branch resolved taken in decode
hold  in  1  external freeze, e.g. memory wait
stall  out  1  hold the PC and fetch/decode register; bubble into execute
flush  out  1  squash the fetch/decode register contents
fwd_sel1  out  SW  0 = register file; k = forward from slot k
fwd_sel2  out  SW  same encoding, for source 2
inflight  out  $clog2(STAGES+1)  count of valid writing slots
stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- Each scoreboard slot k (1..STAGES) holds valid, rd, we and is_load. Reset clears every slot, so all outputs reset to 0.
- All outputs except stall_cnt are combinational from the scoreboard and the decode inputs.
- A match on source n at slot k requires:
  - dec_valid, dec_rsn_used, slot k valid and we set, and slot rd equal to dec_rsn;
  - when ZERO_REG=1, also dec_rsn != 0.
- Forwarding select: the youngest (lowest k) match wins, and fwd_seln = k. With no match, fwd_seln = 0.
- Load-use hazard: the winning match for either source is at slot 1 with is_load set. Load data is not available until slot 2. Older matches never override a younger match.
- stall = hold OR load-use hazard. During a load-use stall, fwd_sel outputs are don't-care but must hold their computed values; they are not forced to 0.
- flush = branch_taken AND dec_valid AND NOT stall. A branch under stall flushes in the first non-stalled cycle, because the decode stage is held.
- Scoreboard update on each rising edge:
  - hold=1: all slots keep their contents (full freeze).
  - Else if load-use hazard: slots k+1 <= k; slot 1 <= bubble (valid=0).
  - Else: slots shift; slot 1 <= {dec_valid, dec_rd, dec_rd_we, dec_is_load}. The oldest slot is discarded.
  - A flush does not invalidate the branch itself; the branch enters slot 1 normally.
- inflight = popcount of (valid AND we) over all slots.
- stall_cnt increments by 1 each cycle that stall=1. It saturates at 2**CNT_W-1 and only returns to 0 on reset.
- Simultaneous matches:
  - Both sources matching the same slot give identical selects.
  - A load at slot 1 matching only source 2 still stalls.
- Reset mid-operation clears all slots immediately (asynchronous). stall, flush and the selects drop in the same cycle.

Test Plan:
- Reset, then an ALU write to r5 followed by an instruction reading r5 as rs1 -> fwd_sel1=1, fwd_sel2=0, stall=0.
- Load r3, then an instruction reading r3 -> stall=1 for exactly 1 cycle, bubble enters slot 1, next cycle fwd_sel1=2; stall_cnt=1.
- Writes to r7 at slots 1 and 3, decode reads r7 -> fwd_sel=1 (youngest wins). Same with slot 1 invalid -> fwd_sel=3.
- branch_taken during a load-use stall -> flush=0 in the stall cycle, flush=1 the next cycle; the branch occupies slot 1 the cycle after that.
- hold=1 for 4 cycles with 3 valid writers in flight -> inflight stays 3, slots unchanged, stall_cnt +4. With ZERO_REG=1 and a write to r0 then a read of r0 -> fwd_sel=0, no stall.
- CNT_W=4, hold=1 for 20 cycles -> stall_cnt saturates at 15. Assert reset mid-run -> all outputs 0 within the same cycle.
